// File: rtl/sc_fifo_arb_pkg.sv
// Shared types and helpers for the sc_fifo write arbiter.
// Holds the FSM state encoding and the id-width rule used by the top and the picker.
package sc_fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;

  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sc_fifo_write_arbiter_rr_select.sv
// Rotate-priority picker: first set request at or above ptr, wrapping past N-1 to 0.
// Purely combinational, zero latency; found=0 when no request is set.
module rr_select
  import sc_fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = id_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] index
);

  int w_pos;

  // Scan offsets from farthest to nearest so the nearest hit overwrites the rest.
  always_comb begin
    found = 1'b0;
    index = '0;
    w_pos = 0;
    for (int i = N - 1; i >= 0; i--) begin
      w_pos = (int'(ptr) + i) % N;
      if (req[w_pos]) begin
        found = 1'b1;
        index = IW'(w_pos);
      end
    end
  end

endmodule

// File: rtl/sc_fifo_write_arbiter.sv
// Round-robin arbiter sharing one sc_fifo write port; grant locked per burst, words tagged with producer id.
// One IDLE grant cycle, then one word per cycle; fifo_full stalls the burst without dropping the grant.
module sc_fifo_write_arbiter
  import sc_fifo_arb_pkg::*;
#(
  parameter int num_requesters = 4,
  parameter int data_width     = 32,
  parameter int max_burst      = 16,
  parameter int id_width       = id_w(num_requesters)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [num_requesters-1:0]            req_valid,
  input  logic [num_requesters*data_width-1:0] req_data,
  input  logic [num_requesters-1:0]            req_last,
  output logic [num_requesters-1:0]            req_ready,
  input  logic                                 fifo_full,
  output logic                                 fifo_write,
  output logic [id_width+data_width-1:0]       fifo_din,
  output logic [id_width-1:0]                  grant_id,
  output logic                                 busy
);

  localparam int                    CNT_W   = $clog2(max_burst + 1);
  localparam logic [CNT_W-1:0]      MAX_CNT = CNT_W'(max_burst);
  localparam logic [id_width-1:0]   LAST_ID = id_width'(num_requesters - 1);

  arb_state_t             r_state;
  logic [id_width-1:0]    r_rr_ptr;
  logic [id_width-1:0]    r_grant_id;
  logic [CNT_W-1:0]       r_burst_cnt;

  logic                   w_found;
  logic [id_width-1:0]    w_pick;
  logic                   w_in_burst;
  logic                   w_g_valid;
  logic                   w_g_last;
  logic [data_width-1:0]  w_g_data;
  logic [CNT_W-1:0]       w_cnt_inc;
  logic [id_width-1:0]    w_next_ptr;
  logic                   w_term;

  rr_select #(
    .N  (num_requesters),
    .IW (id_width)
  ) u_rr_select (
    .req   (req_valid),
    .ptr   (r_rr_ptr),
    .found (w_found),
    .index (w_pick)
  );

  assign w_in_burst = (r_state == ARB_BURST);

  always_comb begin
    w_g_valid = 1'b0;
    w_g_last  = 1'b0;
    w_g_data  = '0;
    req_ready = '0;
    for (int i = 0; i < num_requesters; i++) begin
      if (r_grant_id == id_width'(i)) begin
        w_g_valid    = req_valid[i];
        w_g_last     = req_last[i];
        w_g_data     = req_data[i*data_width +: data_width];
        req_ready[i] = w_in_burst & ~fifo_full;
      end
    end
  end

  assign fifo_write = w_in_burst & w_g_valid & ~fifo_full;
  assign fifo_din   = w_in_burst ? {r_grant_id, w_g_data} : '0;
  assign grant_id   = r_grant_id;
  assign busy       = w_in_burst;

  assign w_cnt_inc  = r_burst_cnt + CNT_W'(1);
  assign w_next_ptr = (r_grant_id == LAST_ID) ? '0 : r_grant_id + id_width'(1);

  // A producer dropping valid only ends the burst when the FIFO could have taken a word.
  assign w_term = (fifo_write & (w_g_last | (w_cnt_inc == MAX_CNT)))
                | (~w_g_valid & ~fifo_full);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ARB_IDLE;
      r_rr_ptr    <= '0;
      r_grant_id  <= '0;
      r_burst_cnt <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_found) begin
            r_grant_id  <= w_pick;
            r_burst_cnt <= '0;
            r_state     <= ARB_BURST;
          end
        end
        ARB_BURST: begin
          if (fifo_write) r_burst_cnt <= w_cnt_inc;
          if (w_term) begin
            r_state  <= ARB_IDLE;
            r_rr_ptr <= w_next_ptr;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_fifo_write_arbiter.sv
// Bench for sc_fifo_write_arbiter: directed scenarios plus a randomized phase,
// all cycles checked against a transaction-level arbiter model and producer queues.
module tb_sc_fifo_write_arbiter;

  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int MB   = 16;
  localparam int IW   = 2;
  localparam int DINW = IW + DW;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } word_t;

  logic            clock     = 1'b0;
  logic            reset     = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data  = '0;
  logic [N-1:0]    req_last  = '0;
  logic [N-1:0]    req_ready;
  logic            fifo_full = 1'b0;
  logic            fifo_write;
  logic [DINW-1:0] fifo_din;
  logic [IW-1:0]   grant_id;
  logic            busy;

  always #5 clock = ~clock;

  sc_fifo_write_arbiter #(
    .num_requesters (N),
    .data_width     (DW),
    .max_burst      (MB)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_write (fifo_write),
    .fifo_din   (fifo_din),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  int n_pass  = 0;
  int n_total = 0;

  word_t        pq[N][$];
  logic [N-1:0] gap       = '0;
  logic         rst_ctl   = 1'b0;
  logic         full_ctl  = 1'b0;
  logic         rand_gaps = 1'b0;

  // Model: owner -1 means nobody holds the port.
  int m_owner    = -1;
  int m_next     = 0;
  int m_sent     = 0;
  int m_last_gid = 0;

  int              grant_log[$];
  int              len_log[$];
  int              idle_log[$];
  logic [DINW-1:0] wr_log[$];
  logic            prev_busy = 1'b0;
  int              cur_len   = 0;
  int              idle_run  = 0;

  word_t           w;
  logic [DINW-1:0] tmp;
  int              p, len, bad, pushed;
  logic            has_last;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += pq[i].size();
    return s;
  endfunction

  task automatic clear_logs();
    grant_log.delete();
    len_log.delete();
    idle_log.delete();
    wr_log.delete();
    cur_len = 0;
  endtask

  task automatic cycle();
    logic [N-1:0]    e_rdy;
    logic            e_wr;
    logic [DINW-1:0] e_din;
    logic            e_busy;
    int              e_gid;
    int              accepted;
    int              pick;
    @(posedge clock);
    #1;
    reset     = rst_ctl;
    fifo_full = full_ctl;
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = (pq[i].size() != 0) && !gap[i];
      req_data[i*DW +: DW]   = (pq[i].size() != 0) ? pq[i][0].d : '0;
      req_last[i]            = (pq[i].size() != 0) ? pq[i][0].l : 1'b0;
    end
    @(negedge clock);
    e_rdy = '0; e_wr = 1'b0; e_din = '0; e_busy = 1'b0;
    e_gid = m_last_gid; accepted = -1; pick = -1;
    if (!rst_ctl) begin
      m_owner = -1; m_next = 0; m_sent = 0; m_last_gid = 0; e_gid = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int c = (m_next + k) % N;
        if (pick < 0 && req_valid[c]) pick = c;
      end
      if (pick >= 0) begin
        m_owner = pick; m_last_gid = pick; m_sent = 0;
      end
    end else begin
      e_busy = 1'b1;
      e_gid  = m_owner;
      if (!fifo_full) e_rdy[m_owner] = 1'b1;
      e_wr  = req_valid[m_owner] && !fifo_full;
      e_din = {IW'(m_owner), req_data[m_owner*DW +: DW]};
      if (e_wr) begin
        accepted = m_owner;
        m_sent++;
        if (req_last[m_owner] || m_sent == MB) begin
          m_next = (m_owner + 1) % N; m_owner = -1;
        end
      end else if (!req_valid[m_owner] && !fifo_full) begin
        m_next = (m_owner + 1) % N; m_owner = -1;
      end
    end
    chk("ready", req_ready, e_rdy);
    chk("write", fifo_write, e_wr);
    chk("din", fifo_din, e_din);
    chk("busy", busy, e_busy);
    chk("grant_id", grant_id, e_gid);
    chk("write_while_full", fifo_write & fifo_full, 0);
    gap = '0;
    if (accepted >= 0) begin
      pq[accepted].delete(0);
      if (rand_gaps && ($urandom % 4 == 0)) gap[accepted] = 1'b1;
    end
    if (fifo_write) begin
      wr_log.push_back(fifo_din);
      cur_len++;
    end
    if (busy && !prev_busy) begin
      grant_log.push_back(int'(grant_id));
      idle_log.push_back(idle_run);
    end
    if (!busy && prev_busy) begin
      len_log.push_back(cur_len);
      cur_len = 0;
    end
    idle_run  = busy ? 0 : idle_run + 1;
    prev_busy = busy;
  endtask

  task automatic run_until_empty(input int bound);
    for (int c = 0; c < bound && pending() != 0; c++) cycle();
    chk("drain_bound", pending(), 0);
  endtask

  task automatic reset_dut();
    rst_ctl = 1'b0;
    repeat (2) cycle();
    rst_ctl = 1'b1;
  endtask

  initial begin
    // Reset state and quiet idle
    repeat (3) cycle();
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_write", fifo_write, 0);
    chk("rst_din", fifo_din, 0);
    chk("rst_gid", grant_id, 0);
    rst_ctl = 1'b1;
    clear_logs();
    repeat (20) cycle();
    chk("idle_writes", wr_log.size(), 0);
    chk("idle_busy", busy, 0);

    // Producer 2, five-word burst
    clear_logs();
    for (int k = 0; k < 5; k++) begin
      w.d = 32'h200 + k; w.l = (k == 4); pq[2].push_back(w);
    end
    run_until_empty(40);
    chk("t2_busy_last_word", busy, 1);
    cycle();
    chk("t2_busy_fall", busy, 0);
    chk("t2_writes", wr_log.size(), 5);
    for (int k = 0; k < 5 && k < wr_log.size(); k++) begin
      tmp = wr_log[k];
      chk("t2_tag", tmp[DINW-1 -: IW], 2);
      chk("t2_data", tmp[DW-1:0], 32'h200 + k);
    end
    // Pointer now at 3: producer 3 wins over producer 0
    clear_logs();
    w.d = 32'h30; w.l = 1'b1; pq[0].push_back(w);
    w.d = 32'h33; w.l = 1'b1; pq[3].push_back(w);
    run_until_empty(20);
    repeat (2) cycle();
    chk("t2_ptr_first", at(grant_log, 0), 3);
    chk("t2_ptr_second", at(grant_log, 1), 0);

    // max_burst cut: 40 words, no last
    clear_logs();
    for (int k = 0; k < 40; k++) begin
      w.d = 32'h300 + k; w.l = 1'b0; pq[0].push_back(w);
    end
    run_until_empty(100);
    repeat (2) cycle();
    chk("t3_nbursts", len_log.size(), 3);
    chk("t3_len0", at(len_log, 0), 16);
    chk("t3_len1", at(len_log, 1), 16);
    chk("t3_len2", at(len_log, 2), 8);
    chk("t3_idle1", at(idle_log, 1), 1);
    chk("t3_idle2", at(idle_log, 2), 1);
    bad = 0;
    for (int k = 0; k < wr_log.size(); k++) begin
      tmp = wr_log[k];
      if (tmp[DINW-1 -: IW] != 0 || tmp[DW-1:0] != 32'h300 + k) bad++;
    end
    chk("t3_writes", wr_log.size(), 40);
    chk("t3_bad_words", bad, 0);

    // Fairness: everyone valid, 3-word bursts
    reset_dut();
    clear_logs();
    for (int i = 0; i < N; i++)
      for (int b = 0; b < 2; b++)
        for (int k = 0; k < 3; k++) begin
          w.d = (i << 8) | (b << 4) | k; w.l = (k == 2); pq[i].push_back(w);
        end
    run_until_empty(100);
    repeat (2) cycle();
    for (int j = 0; j < 6; j++) chk("t4_order", at(grant_log, j), j % N);
    for (int j = 0; j < 8; j++) chk("t4_len", at(len_log, j), 3);
    bad = 0;
    for (int k = 0; k < wr_log.size(); k++) begin
      tmp = wr_log[k];
      if (int'(tmp[DINW-1 -: IW]) != int'(tmp[11:8])) bad++;
    end
    chk("t4_writes", wr_log.size(), 24);
    chk("t4_bad_tags", bad, 0);

    // Back-pressure in the middle of producer 1's burst
    clear_logs();
    for (int k = 0; k < 8; k++) begin
      w.d = 32'h500 + k; w.l = (k == 7); pq[1].push_back(w);
    end
    for (int c = 0; c < 30 && wr_log.size() < 3; c++) cycle();
    chk("t5_pre_words", wr_log.size(), 3);
    full_ctl = 1'b1;
    repeat (7) begin
      cycle();
      chk("t5_write_full", fifo_write, 0);
      chk("t5_ready_full", req_ready[1], 0);
      chk("t5_hold_busy", busy, 1);
      chk("t5_hold_gid", grant_id, 1);
    end
    full_ctl = 1'b0;
    run_until_empty(40);
    repeat (2) cycle();
    chk("t5_writes", wr_log.size(), 8);
    for (int k = 0; k < 8 && k < wr_log.size(); k++) begin
      tmp = wr_log[k];
      chk("t5_data", tmp[DW-1:0], 32'h500 + k);
    end

    // Async reset after word 3 of 8
    clear_logs();
    for (int k = 0; k < 8; k++) begin
      w.d = 32'h600 + k; w.l = (k == 7); pq[2].push_back(w);
    end
    for (int k = 0; k < 2; k++) begin
      w.d = 32'h610 + k; w.l = (k == 1); pq[1].push_back(w);
    end
    for (int c = 0; c < 30 && wr_log.size() < 3; c++) cycle();
    chk("t6_pre_words", wr_log.size(), 3);
    tmp = (wr_log.size() > 0) ? wr_log[0] : '0;
    chk("t6_pre_tag", tmp[DINW-1 -: IW], 2);
    #2;
    rst_ctl = 1'b0;
    reset   = 1'b0;
    #1;
    chk("t6_async_ready", req_ready, 0);
    chk("t6_async_write", fifo_write, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_din", fifo_din, 0);
    repeat (2) cycle();
    rst_ctl = 1'b1;
    clear_logs();
    run_until_empty(60);
    repeat (2) cycle();
    chk("t6_first_grant", at(grant_log, 0), 1);
    chk("t6_writes", wr_log.size(), 7);

    // Randomized traffic with gaps and random fullness
    clear_logs();
    pushed    = 0;
    rand_gaps = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if ($urandom % 3 == 0) begin
        p = int'($urandom % N);
        if (pq[p].size() < 30) begin
          len      = int'($urandom_range(1, 20));
          has_last = ($urandom % 4 != 0);
          for (int k = 0; k < len; k++) begin
            w.d = $urandom; w.l = has_last && (k == len - 1); pq[p].push_back(w);
          end
          pushed += len;
        end
      end
      full_ctl = ($urandom % 4 == 0);
      cycle();
    end
    full_ctl  = 1'b0;
    rand_gaps = 1'b0;
    run_until_empty(3000);
    repeat (3) cycle();
    chk("rand_words", wr_log.size(), pushed);
    chk("rand_final_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
